// File: rtl/delay_pkg.sv
// Shared constants and width helper for the delay_line block.
package delay_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 272;
    localparam int unsigned DEFAULT_DEPTH      = 4;

    // Bits needed to encode a stage count from 0 to depth inclusive.
    function automatic int unsigned len_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/delay_stage.sv
// One data+valid register of the delay line: loads on en, valid-clear
// drops only the valid bit, reset zeroes both.
module delay_stage
    import delay_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  clr_valid,
    input  logic [DATA_WIDTH-1:0] d,
    input  logic                  valid_d,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  valid_q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q       <= '0;
            valid_q <= 1'b0;
        end else if (clr_valid) begin
            valid_q <= 1'b0;
        end else if (en) begin
            q       <= d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/delay_line.sv
// Variable-length delay line: DEPTH register stages with a combinational tap
// select. Define DELAY_LINE_OCC_EN to add the delay_occ occupancy counter.
module delay_line
    import delay_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEFAULT_DEPTH,
    parameter int unsigned LEN_WIDTH  = len_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  delay_en,
    input  logic                  flush,
    input  logic                  delay_valid_in,
    input  logic [DATA_WIDTH-1:0] delay_in,
    input  logic [LEN_WIDTH-1:0]  delay_len,
    output logic [DATA_WIDTH-1:0] delay_out,
    output logic                  delay_valid_out
`ifdef DELAY_LINE_OCC_EN
    ,
    output logic [LEN_WIDTH-1:0]  delay_occ
`endif
);

    logic [DATA_WIDTH-1:0] stage_data [DEPTH];
    logic [DEPTH-1:0]      stage_valid;
    int unsigned           tap_idx;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            delay_stage #(
                .DATA_WIDTH(DATA_WIDTH)
            ) u_stage (
                .clk       (clk),
                .rst_n     (rst_n),
                .en        (delay_en),
                .clr_valid (flush),
                .d         (delay_in),
                .valid_d   (delay_valid_in),
                .q         (stage_data[i]),
                .valid_q   (stage_valid[i])
            );
        end else begin : g_body
            delay_stage #(
                .DATA_WIDTH(DATA_WIDTH)
            ) u_stage (
                .clk       (clk),
                .rst_n     (rst_n),
                .en        (delay_en),
                .clr_valid (flush),
                .d         (stage_data[i-1]),
                .valid_d   (stage_valid[i-1]),
                .q         (stage_data[i]),
                .valid_q   (stage_valid[i])
            );
        end
    end

    // Clamp the requested length to 1..DEPTH and select stage[L-1].
    always_comb begin
        tap_idx = 0;
        if (32'(delay_len) == 0) begin
            tap_idx = 0;
        end else if (32'(delay_len) > DEPTH) begin
            tap_idx = DEPTH - 1;
        end else begin
            tap_idx = 32'(delay_len) - 1;
        end
    end

    always_comb begin
        delay_out       = '0;
        delay_valid_out = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (i == tap_idx) begin
                delay_out       = stage_data[i];
                delay_valid_out = stage_valid[i];
            end
        end
    end

`ifdef DELAY_LINE_OCC_EN
    int                   occ_sum;
    logic [LEN_WIDTH-1:0] occ_next;

    always_comb begin
        occ_sum = int'(32'(delay_occ)) + int'(32'(delay_valid_in))
                - int'(32'(stage_valid[DEPTH-1]));
        if (occ_sum < 0) begin
            occ_sum = 0;
        end else if (occ_sum > int'(DEPTH)) begin
            occ_sum = int'(DEPTH);
        end
        occ_next = LEN_WIDTH'(occ_sum);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            delay_occ <= '0;
        end else if (flush) begin
            delay_occ <= '0;
        end else if (delay_en) begin
            delay_occ <= occ_next;
        end
    end
`endif

endmodule

// File: tb/tb_delay_line.sv
// Scoreboard bench for delay_line (DEPTH=4, DATA_WIDTH=272); occupancy
// checks are compiled in when DELAY_LINE_OCC_EN is defined.
module tb_delay_line;

    localparam int unsigned DW    = 272;
    localparam int unsigned DEP   = 4;
    localparam int unsigned LW    = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           delay_en;
    logic           flush;
    logic           delay_valid_in;
    logic [DW-1:0]  delay_in;
    logic [LW-1:0]  delay_len;
    logic [DW-1:0]  delay_out;
    logic           delay_valid_out;
`ifdef DELAY_LINE_OCC_EN
    logic [LW-1:0]  delay_occ;
`endif

    delay_line #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEP)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .delay_en        (delay_en),
        .flush           (flush),
        .delay_valid_in  (delay_valid_in),
        .delay_in        (delay_in),
        .delay_len       (delay_len),
        .delay_out       (delay_out),
        .delay_valid_out (delay_valid_out)
`ifdef DELAY_LINE_OCC_EN
        ,
        .delay_occ       (delay_occ)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          valid;
        int            occ;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] m_data [DEP];
    logic          m_val  [DEP];
    int            m_occ;
    int            n_vec = 0;
    int            n_err = 0;

    task automatic check(input string tag, input logic [DW-1:0] got,
                         input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected tap output from the reference state, pushed into the scoreboard.
    task automatic expect_now();
        exp_t        e;
        int unsigned l;
        l = 32'(delay_len);
        if (l == 0) l = 1;
        if (l > DEP) l = DEP;
        e.data  = m_data[l-1];
        e.valid = m_val[l-1];
        e.occ   = m_occ;
        sb.push_back(e);
    endtask

    task automatic compare_head(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 1, 0);
            return;
        end
        e = sb.pop_front();
        check({tag, "_data"}, delay_out, e.data);
        check({tag, "_valid"}, DW'(delay_valid_out), DW'(e.valid));
`ifdef DELAY_LINE_OCC_EN
        check({tag, "_occ"}, DW'(delay_occ), DW'(e.occ));
`endif
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            for (int i = 0; i < DEP; i++) begin
                m_data[i] = '0;
                m_val[i]  = 1'b0;
            end
            m_occ = 0;
        end else if (flush) begin
            for (int i = 0; i < DEP; i++) m_val[i] = 1'b0;
            m_occ = 0;
        end else if (delay_en) begin
            m_occ = m_occ + int'(delay_valid_in) - int'(m_val[DEP-1]);
            if (m_occ < 0) m_occ = 0;
            if (m_occ > DEP) m_occ = DEP;
            for (int i = DEP - 1; i > 0; i--) begin
                m_data[i] = m_data[i-1];
                m_val[i]  = m_val[i-1];
            end
            m_data[0] = delay_in;
            m_val[0]  = delay_valid_in;
        end
    endtask

    task automatic tick(input string tag, input logic en, input logic fl,
                        input logic vin, input logic [DW-1:0] din);
        delay_en       = en;
        flush          = fl;
        delay_valid_in = vin;
        delay_in       = din;
        @(posedge clk);
        model_edge();
        #1;
        expect_now();
        compare_head(tag);
    endtask

    task automatic rnd_word(output logic [DW-1:0] w);
        for (int i = 0; i < 9; i++) w = {w[DW-33:0], 32'($urandom)};
    endtask

    logic [DW-1:0] rw;
    logic [DW-1:0] ones;

    initial begin
        ones           = '1;
        rst_n          = 1'b0;
        delay_en       = 1'b1;
        flush          = 1'b0;
        delay_valid_in = 1'b1;
        delay_in       = ones;
        delay_len      = 3'd3;
        for (int i = 0; i < DEP; i++) begin
            m_data[i] = 'x;
            m_val[i]  = 1'bx;
        end
        m_occ = 0;

        // Reset held two edges with all-ones input.
        tick("rst0", 1, 0, 1, ones);
        tick("rst1", 1, 0, 1, ones);
        check("rst_out", delay_out, '0);
        check("rst_vld", DW'(delay_valid_out), '0);
        rst_n = 1'b1;

        // Fixed latency of three edges.
        tick("lat1", 1, 0, 1, DW'(32'h11));
        tick("lat2", 1, 0, 1, DW'(32'h22));
        tick("lat3", 1, 0, 1, DW'(32'h33));
        check("lat_11", delay_out, DW'(32'h11));
        check("lat_11v", DW'(delay_valid_out), DW'(1));
        tick("lat4", 1, 0, 1, DW'(32'h55));
        check("lat_22", delay_out, DW'(32'h22));
        tick("lat5", 1, 0, 1, DW'(32'h66));
        check("lat_33", delay_out, DW'(32'h33));

        // Stall: five cycles without enable, input changing underneath.
        for (int i = 0; i < 5; i++) begin
            rnd_word(rw);
            tick("stall", 0, 0, 1, rw);
            check("stall_hold", delay_out, DW'(32'h33));
        end
        tick("resume", 1, 0, 0, '0);
        check("resume_55", delay_out, DW'(32'h55));

        // Flush with a valid input pending.
        tick("fl_a", 1, 0, 1, DW'(32'hA1));
        tick("fl_b", 1, 0, 1, DW'(32'hA2));
        tick("fl_c", 1, 0, 1, DW'(32'hA3));
        tick("flush", 1, 1, 1, DW'(32'h44));
        delay_len = 3'd4;
        for (int i = 0; i < DEP + 1; i++) begin
            tick("post_fl", 1, 0, 0, '0);
            check("fl_vld0", DW'(delay_valid_out), '0);
            check("fl_no44", DW'(delay_out == DW'(32'h44)), '0);
        end

        // Length clamp and same-cycle switch.
        tick("ln1", 1, 0, 1, DW'(32'hB1));
        tick("ln2", 1, 0, 1, DW'(32'hB2));
        tick("ln3", 1, 0, 1, DW'(32'hB3));
        tick("ln4", 1, 0, 1, DW'(32'hB4));
        delay_len = 3'd0;
        #1;
        expect_now();
        compare_head("len0");
        check("len0_b4", delay_out, DW'(32'hB4));
        delay_len = 3'd7;
        #1;
        expect_now();
        compare_head("len7");
        check("len7_b1", delay_out, DW'(32'hB1));

        // Reset mid-stream discards everything in flight.
        rst_n = 1'b0;
        tick("mid_rst", 1, 1, 1, ones);
        check("mid_rst_out", delay_out, '0);
        rst_n = 1'b1;

        // Occupancy saturates at DEPTH.
        delay_len = 3'd1;
        for (int i = 0; i < 6; i++) begin
            tick("sat", 1, 0, 1, DW'(32'hC0 + i));
`ifdef DELAY_LINE_OCC_EN
            check("occ_sat", DW'(delay_occ), DW'((i < 4) ? i + 1 : 4));
`endif
        end

        // Random mix of enable, flush, valid and length.
        for (int i = 0; i < 60; i++) begin
            rnd_word(rw);
            delay_len = 3'($urandom_range(0, 7));
            tick("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 1)), rw);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/delay_line.md
DELAY_LINE -- requirements
Module: delay_line

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 272, the data bits per stage.
REQ-002 The block SHALL have parameter DEPTH, default 4, the number of register stages; legal range 1..256.
REQ-003 The block SHALL have parameter LEN_WIDTH, default $clog2(DEPTH+1), the width of delay_len and delay_occ.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port delay_en, input, 1 bit: advance all stages by one when high.
REQ-007 The block SHALL have port flush, input, 1 bit: invalidate all stages.
REQ-008 The block SHALL have port delay_valid_in, input, 1 bit: delay_in carries valid data.
REQ-009 The block SHALL have port delay_in, input, DATA_WIDTH bits: data into stage 0.
REQ-010 The block SHALL have port delay_len, input, LEN_WIDTH bits: selected delay in stages.
REQ-011 The block SHALL have port delay_out, output, DATA_WIDTH bits: data from the selected tap.
REQ-012 The block SHALL have port delay_valid_out, output, 1 bit: valid bit of the selected tap.
REQ-013 The block SHALL have port delay_occ, output, LEN_WIDTH bits: count of valid stages. Present only with DELAY_LINE_OCC_EN.

Function
REQ-014 The block SHALL, on a clock edge with delay_en=1 and flush=0, load stage[0] with delay_in/delay_valid_in and load stage[i] with stage[i-1] for i=1..DEPTH-1.
REQ-015 The block SHALL, on a clock edge with delay_en=0 and flush=0, hold all data and valid bits unchanged.
REQ-016 The block SHALL, on a clock edge with flush=1, clear every valid bit, leave data registers unchanged and discard delay_in regardless of delay_en.
REQ-017 Effective length L SHALL be delay_len clamped to 1..DEPTH: 0 maps to 1, and values above DEPTH map to DEPTH.
REQ-018 delay_out and delay_valid_out SHALL be a combinational select of stage[L-1]; a delay_len change takes effect in the same cycle with no pipeline bubble.
REQ-019 Latency SHALL be exactly L delay_en-qualified edges from sampling delay_in to its appearance on delay_out.
REQ-020 The data pushed out of stage[DEPTH-1] SHALL be dropped silently; no overflow indication is given.
REQ-021 The block SHALL update valid bits with data in every case: an invalid word (delay_valid_in=0) still shifts its data.

Reset
REQ-022 The block SHALL, while rst_n=0 at a clock edge, clear all data registers to all-zero (full DATA_WIDTH), all valid bits to 0 and delay_occ to 0.
REQ-023 Reset SHALL have priority over flush and delay_en.
REQ-024 After reset, delay_out SHALL be 0 and delay_valid_out SHALL be 0 until valid data reaches tap L-1.
REQ-025 Reset asserted mid-operation SHALL discard all in-flight words, with no partial shift.

Configuration
REQ-026 With macro DELAY_LINE_OCC_EN defined, the block SHALL provide port delay_occ as a registered count of set valid bits over all DEPTH stages, updated in the same edge as the valid bits.
REQ-027 delay_occ SHALL become 0 on flush and stay unchanged when delay_en=0.
REQ-028 When delay_en=1, delay_occ SHALL change by +delay_valid_in minus the valid bit of stage[DEPTH-1], saturating within 0..DEPTH.
REQ-029 Without DELAY_LINE_OCC_EN, the delay_occ port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-030 Package delay_pkg SHALL hold the default DATA_WIDTH (272) and DEPTH (4) constants and a function for the LEN_WIDTH computation.
REQ-031 Sub-module delay_stage SHALL be one data+valid register with enable and valid-clear, instantiated DEPTH times in a generate loop.
REQ-032 The tap mux and the occupancy counter SHALL live in delay_line.

Verification
REQ-033 Reset: hold rst_n=0 for 2 edges with delay_en=1 and delay_in=all-ones -> delay_out=0, delay_valid_out=0, delay_occ=0.
REQ-034 Fixed latency: DEPTH=4, delay_len=3, delay_en=1, push 0x11,0x22,0x33 valid on consecutive edges -> 0x11 appears valid after the 3rd edge, then 0x22 and 0x33 on the next edges.
REQ-035 Stall: delay_en=0 for 5 cycles mid-stream -> outputs frozen, delay_occ constant, and the sequence resumes unchanged.
REQ-036 Flush: stages holding 3 valid words, assert flush with delay_en=1 and valid input 0x44 -> all valid bits 0, delay_occ=0, and 0x44 never emerges.
REQ-037 Length clamp/switch: delay_len=0 then 7 with DEPTH=4 -> behaves as L=1 then L=4, and the switch is visible in the same cycle.
REQ-038 Occupancy saturation: 6 consecutive valid pushes with DEPTH=4 -> delay_occ sequence 1,2,3,4,4,4.
